// File: rtl/r8_mbe_pp_prep.sv
// Two-stage operand prep for a radix-8 modified-Booth multiplier: registers the
// 1A/2A/3A/4A multiples of a and the nine signed-digit select codes recoded from b.
module r8_mbe_pp_prep #(
    parameter int unsigned W = 24,
    localparam int unsigned XW = W + 3,
    localparam int unsigned ND = W / 3 + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XW-1:0]   x_1,
    output logic [XW-1:0]   x_2,
    output logic [XW-1:0]   x_3,
    output logic [XW-1:0]   x_4,
    output logic [5*ND-1:0] be_sel
);

    localparam int unsigned BXW = 3 * ND + 1;

    logic           v1;
    logic [W-1:0]   a1;
    logic [W-1:0]   b1;
    logic           s1_ready_c;
    logic           s2_ready_c;
    logic [XW-1:0]  x3_c;
    logic [BXW-1:0] bx_c;
    logic [5*ND-1:0] sel_c;

    // Group {b[3i+2], b[3i+1], b[3i], b[3i-1]} -> one-hot magnitude, bit 4 = negative.
    function automatic logic [4:0] booth_code(input logic [3:0] g);
        logic [4:0] code;
        code = 5'b00000;
        case (g)
            4'b0001, 4'b0010: code = 5'b00001;
            4'b0011, 4'b0100: code = 5'b00010;
            4'b0101, 4'b0110: code = 5'b00100;
            4'b0111:          code = 5'b01000;
            4'b1000:          code = 5'b11000;
            4'b1001, 4'b1010: code = 5'b10100;
            4'b1011, 4'b1100: code = 5'b10010;
            4'b1101, 4'b1110: code = 5'b10001;
            default:          code = 5'b00000;
        endcase
        return code;
    endfunction

    assign s2_ready_c = !out_valid || out_ready;
    assign s1_ready_c = !v1 || s2_ready_c;
    assign in_ready   = s1_ready_c;

    // 3A is the only carry-propagate add; it sits between the two stage registers.
    assign x3_c = XW'(a1) + XW'({a1, 1'b0});

    // b shifted left by one supplies b[-1] = 0; upper pad bits supply b[>=W] = 0.
    assign bx_c = BXW'({b1, 1'b0});

    always_comb begin
        sel_c = '0;
        for (int i = 0; i < int'(ND); i++) begin
            sel_c[5*i +: 5] = booth_code(bx_c[3*i +: 4]);
        end
    end

    // Stage 1: operand capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            a1 <= '0;
            b1 <= '0;
        end else begin
            if (s1_ready_c) begin
                v1 <= in_valid;
            end
            if (in_valid && s1_ready_c) begin
                a1 <= a;
                b1 <= b;
            end
        end
    end

    // Stage 2: multiples and select codes, all outputs come straight from here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            x_1       <= '0;
            x_2       <= '0;
            x_3       <= '0;
            x_4       <= '0;
            be_sel    <= '0;
        end else begin
            if (s2_ready_c) begin
                out_valid <= v1;
            end
            if (v1 && s2_ready_c) begin
                x_1    <= XW'(a1);
                x_2    <= XW'({a1, 1'b0});
                x_3    <= x3_c;
                x_4    <= XW'({a1, 2'b00});
                be_sel <= sel_c;
            end
        end
    end

endmodule
